vedic_mult_pipe: RTL
====================

Name: vedic_mult_pipe

Overview:
- Parametrised, pipelined NxN Vedic multiplier using the Urdhva-Tiryagbhyam quadrant method. Operates in unsigned or signed mode, selectable per transaction.
- Generation after the fixed 8x8 combinational multiplier built from ha / add_4_bit / add_6_bit.
- Adds valid/ready flow control, 3-stage pipelining and backpressure.
- Sits between the operand source and the accumulate/datapath logic.

Parameters:
- WIDTH, 8, operand width in bits; power of two, minimum 4.
- HALF, WIDTH/2, quadrant width; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result.

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset is asynchronous and active-low: rst_n.
  - While rst_n = 0: all stage valid flags = 0, out_valid = 0, product = 0, all pipeline data registers = 0.
  - in_ready = 1 from the first cycle after reset release.
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - a, b and is_signed are sampled only on an input transfer.
  - product and out_valid hold stable while out_valid & !out_ready.
- Pipeline: stages S1, S2, S3, each with its own valid bit v1, v2, v3.
  - S1: if is_signed, take the magnitudes of a and b and record neg = a[MSB] ^ b[MSB]; else neg = 0. Split |a|, |b| into high/low HALF halves and register the four HALFxHALF partial products ll, lh, hl, hh (each WIDTH bits).
  - S2: mid = lh + hl, WIDTH+1 bits, carry kept. Register ll, hh, mid, neg.
  - S3: mag = {hh, ll} + (mid << HALF), 2*WIDTH bits, no overflow possible. product = neg ? -mag : mag.
- Magnitude of the most negative value (-2^(WIDTH-1)) is 2^(WIDTH-1) and must be handled without overflow. Operand magnitudes are WIDTH bits unsigned.
- Advance rule:
  - Stage k loads when its successor is empty or advancing.
  - adv3 = !v3 | out_ready; adv2 = !v2 | adv3; adv1 = !v1 | adv2; in_ready = adv1.
  - This is a fully combinational ready chain with no skid buffer.
- Latency and throughput:
  - Latency 3 cycles from input transfer to out_valid when unstalled.
  - Throughput 1 result per cycle with out_ready held at 1.
- Backpressure:
  - With out_ready = 0, the pipeline fills to 3 entries, then in_ready = 0.
  - No data is lost or duplicated. Results leave in acceptance order.
- Simultaneous input and output transfer on a full pipeline is legal and keeps occupancy at 3.
- Reset asserted mid-operation: all in-flight results are discarded immediately (asynchronous); nothing is emitted afterward.
- is_signed = 0: a and b are treated as unsigned; the full 2*WIDTH result is returned with no truncation.

Decomposition:
- Package vedic_pkg holds:
  - function abs_val(value, is_signed)
  - localparam NUM_STAGES = 3
  - the assertion that WIDTH is a power of two, ≥ 4
- Sub-module vedic_mult_comb (parameter W): combinational, recursive WxW Urdhva multiplier.
  - Base case W = 2 uses ha instances.
  - Recursive case uses four W/2 instances plus a width-parametrised adder, replacing the fixed add_4_bit / add_6_bit.
  - vedic_mult_pipe instantiates four vedic_mult_comb #(HALF) in S1.

Test Plan:
- WIDTH = 8, unsigned, a = 255, b = 255, out_ready = 1 → product = 16'hFE01, 3 cycles after the accept.
- WIDTH = 8, signed:
  - a = 8'h80, b = 8'h80 → 16'h4000.
  - a = 8'hFF, b = 8'h01 → 16'hFFFF.
  - a = 8'h80, b = 8'h7F → 16'hC080.
- Back-to-back: 100 random operand pairs on consecutive cycles, out_ready = 1 → 100 consecutive out_valid cycles; each matches a reference model, in order. Repeat with WIDTH = 16.
- Backpressure:
  - Hold out_ready = 0 → in_ready drops after exactly 3 accepts; product stays stable.
  - Release → 3 results drain in order; in_ready returns to 1 in the same cycle out_ready goes high.
- Random out_ready (50% duty) with random in_valid → no loss or duplication; scoreboard match; handshake-stability assertions pass.
- Assert rst_n low with 2 results in flight → out_valid = 0 and product = 0 immediately; no stale output after release; in_ready = 1 on the first cycle after release.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
package vedic_pkg;

   localparam int NUM_STAGES = 3;
   localparam int MAX_WIDTH  = 64;

   typedef logic [MAX_WIDTH-1:0] word_t;

   // Legal operand widths: power of two, at least 4, with headroom below MAX_WIDTH.
   function automatic bit width_ok(input int w);
      return (w >= 4) && (w <= MAX_WIDTH / 2) && ((w & (w - 1)) == 0);
   endfunction

   // Caller sign- or zero-extends to MAX_WIDTH, so -2^(W-1) yields 2^(W-1) without overflow.
   function automatic word_t abs_val(input word_t value, input logic is_signed);
      return (is_signed && value[MAX_WIDTH-1]) ? word_t'(-value) : value;
   endfunction

endpackage

// File: rtl/vedic_mult_comb.sv
// Recursive combinational Urdhva-Tiryagbhyam multiplier: 2x2 leaf from half adders,
// larger sizes from four half-width quadrants and a parametrised adder.
module ha (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module vedic_add #(
   parameter int N = 8
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   output logic [N-1:0] sum
);
   assign sum = x + y;
endmodule

module vedic_mult_comb #(
   parameter int W = 4
) (
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] p
);
   localparam int H = W / 2;

   if (W == 2) begin : g_base
      logic c1;
      assign p[0] = a[0] & b[0];
      ha u_ha0 (.a(a[1] & b[0]), .b(a[0] & b[1]), .s(p[1]), .c(c1));
      ha u_ha1 (.a(a[1] & b[1]), .b(c1),          .s(p[2]), .c(p[3]));
   end else begin : g_rec
      logic [W-1:0]   ll, lh, hl, hh;
      logic [W:0]     mid;
      logic [2*W-1:0] mid_shift;

      vedic_mult_comb #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
      vedic_mult_comb #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
      vedic_mult_comb #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
      vedic_mult_comb #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));

      vedic_add #(.N(W + 1)) u_mid (.x({1'b0, lh}), .y({1'b0, hl}), .sum(mid));
      assign mid_shift = {{(W - 1){1'b0}}, mid} << H;
      vedic_add #(.N(2 * W)) u_fin (.x({hh, ll}), .y(mid_shift), .sum(p));
   end
endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage valid/ready NxN Vedic multiplier, signed or unsigned per transaction.
module vedic_mult_pipe
   import vedic_pkg::*;
#(
   parameter int  WIDTH = 8,
   localparam int HALF  = WIDTH / 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   if (!width_ok(WIDTH)) begin : g_width_check
      $error("vedic_mult_pipe: WIDTH must be a power of two >= 4");
   end

   logic adv1, adv2, adv3, in_xfer;
   logic v1_q, v2_q, v3_q;

   logic [MAX_WIDTH-WIDTH-1:0] unused_hi_a, unused_hi_b;
   logic [WIDTH-1:0]           mag_a, mag_b;
   logic [WIDTH-1:0]           ll_d, lh_d, hl_d, hh_d;
   logic                       neg_d;

   logic [WIDTH-1:0]   ll_q, lh_q, hl_q, hh_q;
   logic               neg1_q;
   logic [WIDTH:0]     mid_d, mid_q;
   logic [WIDTH-1:0]   ll2_q, hh2_q;
   logic               neg2_q;
   logic [2*WIDTH-1:0] mag_d, product_d, product_q;

   // Combinational ready chain: a stage may load when its successor is empty or draining.
   assign adv3     = !v3_q || out_ready;
   assign adv2     = !v2_q || adv3;
   assign adv1     = !v1_q || adv2;
   assign in_ready = adv1;
   assign in_xfer  = in_valid && adv1;

   assign {unused_hi_a, mag_a} =
      abs_val({{(MAX_WIDTH - WIDTH){a[WIDTH-1] & is_signed}}, a}, is_signed);
   assign {unused_hi_b, mag_b} =
      abs_val({{(MAX_WIDTH - WIDTH){b[WIDTH-1] & is_signed}}, b}, is_signed);
   assign neg_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);

   vedic_mult_comb #(.W(HALF)) u_pp_ll (.a(mag_a[HALF-1:0]),     .b(mag_b[HALF-1:0]),     .p(ll_d));
   vedic_mult_comb #(.W(HALF)) u_pp_lh (.a(mag_a[HALF-1:0]),     .b(mag_b[WIDTH-1:HALF]), .p(lh_d));
   vedic_mult_comb #(.W(HALF)) u_pp_hl (.a(mag_a[WIDTH-1:HALF]), .b(mag_b[HALF-1:0]),     .p(hl_d));
   vedic_mult_comb #(.W(HALF)) u_pp_hh (.a(mag_a[WIDTH-1:HALF]), .b(mag_b[WIDTH-1:HALF]), .p(hh_d));

   assign mid_d     = {1'b0, lh_q} + {1'b0, hl_q};
   assign mag_d     = {hh2_q, ll2_q} + ({{(WIDTH - 1){1'b0}}, mid_q} << HALF);
   assign product_d = neg2_q ? -mag_d : mag_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         v3_q      <= 1'b0;
         ll_q      <= '0;
         lh_q      <= '0;
         hl_q      <= '0;
         hh_q      <= '0;
         neg1_q    <= 1'b0;
         ll2_q     <= '0;
         hh2_q     <= '0;
         mid_q     <= '0;
         neg2_q    <= 1'b0;
         product_q <= '0;
      end else begin
         if (adv1) v1_q <= in_valid;
         if (in_xfer) begin
            ll_q   <= ll_d;
            lh_q   <= lh_d;
            hl_q   <= hl_d;
            hh_q   <= hh_d;
            neg1_q <= neg_d;
         end
         if (adv2) v2_q <= v1_q;
         if (v1_q && adv2) begin
            ll2_q  <= ll_q;
            hh2_q  <= hh_q;
            mid_q  <= mid_d;
            neg2_q <= neg1_q;
         end
         // Product register only moves on a real load, so it holds while stalled.
         if (adv3) v3_q <= v2_q;
         if (v2_q && adv3) product_q <= product_d;
      end
   end

   assign out_valid = v3_q;
   assign product   = product_q;

endmodule
